srl_fifo: RTL and testbench

//  Parametrised synchronous FIFO built on an inferred SRL-style shift register (no reset on storage).

---
 rtl/srl_fifo.sv | 122 ++++++++++++
 tb/tb_srl_fifo.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/srl_fifo.sv
// Synchronous FIFO on an un-reset shift register so synthesis can map storage to SRL/LUT-RAM.
// Define SRL_FIFO_OREG_EN to add a registered output stage (capacity DEPTH+1, 2-edge latency).
`timescale 1ns/1ps
module srl_fifo #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned DEPTH     = 32,
  parameter int unsigned AFULL_THR = 28
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     WR_EN,
  input  logic [WIDTH-1:0]         DIN,
  output logic                     FULL,
  output logic                     AFULL,
  input  logic                     RD_EN,
  output logic [WIDTH-1:0]         DOUT,
  output logic                     VALID,
  output logic [$clog2(DEPTH):0]   COUNT,
  output logic                     OVF,
  output logic                     UDF
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] sr_q [DEPTH];
  logic [CW-1:0]    srl_cnt_q, srl_cnt_d;
  logic [AW-1:0]    rd_idx;
  logic [WIDTH-1:0] srl_head;
  logic             srl_full;
  logic             srl_nonempty;
  logic             wr_acc;
  logic             rd_acc;
  logic             srl_pop;
  logic             valid_int;
  logic             ovf_q, udf_q;

  assign srl_full     = (srl_cnt_q == CW'(DEPTH));
  assign srl_nonempty = (srl_cnt_q != '0);
  assign wr_acc       = WR_EN & ~srl_full;

  // Oldest entry sits at COUNT-1; the low bits wrap correctly when the stage is full.
  assign rd_idx   = srl_cnt_q[AW-1:0] - AW'(1);
  assign srl_head = sr_q[rd_idx];

  // Storage has no reset so it stays inferable as a shift-register primitive.
  always_ff @(posedge CLK) begin
    if (wr_acc) begin
      sr_q[0] <= DIN;
      for (int i = 1; i < int'(DEPTH); i++) begin
        sr_q[i] <= sr_q[i-1];
      end
    end
  end

  always_comb begin
    srl_cnt_d = srl_cnt_q;
    unique case ({wr_acc, srl_pop})
      2'b10:   srl_cnt_d = srl_cnt_q + CW'(1);
      2'b01:   srl_cnt_d = srl_cnt_q - CW'(1);
      default: srl_cnt_d = srl_cnt_q;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      srl_cnt_q <= '0;
    end else begin
      srl_cnt_q <= srl_cnt_d;
    end
  end

`ifdef SRL_FIFO_OREG_EN
  logic [WIDTH-1:0] oreg_q;
  logic             oreg_vld_q;

  assign valid_int = oreg_vld_q;
  assign rd_acc    = RD_EN & oreg_vld_q;
  // Refill the output register whenever it is (or is about to be) empty.
  assign srl_pop   = (~oreg_vld_q | rd_acc) & srl_nonempty;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      oreg_q     <= '0;
      oreg_vld_q <= 1'b0;
    end else if (srl_pop) begin
      oreg_q     <= srl_head;
      oreg_vld_q <= 1'b1;
    end else if (rd_acc) begin
      oreg_q     <= '0;
      oreg_vld_q <= 1'b0;
    end
  end

  assign DOUT  = oreg_q;
  assign COUNT = srl_cnt_q + {{(CW-1){1'b0}}, oreg_vld_q};
`else
  assign valid_int = srl_nonempty;
  assign rd_acc    = RD_EN & srl_nonempty;
  assign srl_pop   = rd_acc;

  assign DOUT  = srl_nonempty ? srl_head : '0;
  assign COUNT = srl_cnt_q;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      if (WR_EN && srl_full) ovf_q <= 1'b1;
      if (RD_EN && !valid_int) udf_q <= 1'b1;
    end
  end

  assign VALID = valid_int;
  assign FULL  = srl_full;
  assign AFULL = (32'(COUNT) >= AFULL_THR);
  assign OVF   = ovf_q;
  assign UDF   = udf_q;

endmodule

// File: tb/tb_srl_fifo.sv
// Scoreboard bench for srl_fifo in its default build (WIDTH=8, DEPTH=32, AFULL_THR=28).
`timescale 1ns/1ps
module tb_srl_fifo;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned THR   = 28;

  logic             clk = 1'b0;
  logic             rst;
  logic             wr_en, rd_en;
  logic [WIDTH-1:0] din;
  logic             full, afull, valid, ovf, udf;
  logic [WIDTH-1:0] dout;
  logic [5:0]       count;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  logic [WIDTH-1:0] sb_q[$];
  logic             m_ovf, m_udf;

  always #5 clk = ~clk;

  srl_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AFULL_THR(THR)) dut (
    .CLK   (clk),
    .RST   (rst),
    .WR_EN (wr_en),
    .DIN   (din),
    .FULL  (full),
    .AFULL (afull),
    .RD_EN (rd_en),
    .DOUT  (dout),
    .VALID (valid),
    .COUNT (count),
    .OVF   (ovf),
    .UDF   (udf)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    int unsigned c;
    c = sb_q.size();
    check_eq("count", 32'(count), c);
    check_eq("valid", 32'(valid), 32'(c != 0));
    check_eq("full",  32'(full),  32'(c == DEPTH));
    check_eq("afull", 32'(afull), 32'(c >= THR));
    check_eq("ovf",   32'(ovf),   32'(m_ovf));
    check_eq("udf",   32'(udf),   32'(m_udf));
    if (c == 0) check_eq("dout_empty", 32'(dout), 0);
  endtask

  // One clock of stimulus: check outputs, pop expectation on accepted read, update model at edge.
  task automatic step(input logic wr, input logic [WIDTH-1:0] d, input logic rd);
    int unsigned c;
    logic        wa;
    logic [WIDTH-1:0] exp_d;
    @(negedge clk);
    check_state();
    c  = sb_q.size();
    wa = wr && (c != DEPTH);
    if (rd && c != 0) begin
      exp_d = sb_q.pop_front();
      check_eq("dout_pop", 32'(dout), 32'(exp_d));
    end
    if (wr && c == DEPTH) m_ovf = 1'b1;
    if (rd && c == 0)     m_udf = 1'b1;
    wr_en = wr;
    din   = d;
    rd_en = rd;
    @(posedge clk);
    if (wa) sb_q.push_back(d);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
  endtask

  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check_eq("rst_count", 32'(count), 0);
    check_eq("rst_valid", 32'(valid), 0);
    check_eq("rst_dout",  32'(dout),  0);
    check_eq("rst_ovf",   32'(ovf),   0);
    check_eq("rst_udf",   32'(udf),   0);
    check_eq("rst_full",  32'(full),  0);
    check_eq("rst_afull", 32'(afull), 0);
    sb_q.delete();
    m_ovf = 1'b0;
    m_udf = 1'b0;
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = '0;
    m_ovf = 1'b0;
    m_udf = 1'b0;
    #12;
    check_state();
    rst = 1'b0;

    // Reset mid-run with 5 entries held, then the next write must act as into empty.
    for (int i = 0; i < 5; i++) step(1'b1, WIDTH'(8'h30 + i), 1'b0);
    check_eq("pre_rst_count", 32'(count), 5);
    async_reset();
    step(1'b1, 8'h77, 1'b0);
    check_eq("post_rst_dout", 32'(dout), 32'h77);
    step(1'b0, 8'h00, 1'b1);

    // Fill with 0x01..0x20; AFULL and FULL are tracked by check_state on every cycle.
    for (int i = 1; i <= 32; i++) step(1'b1, WIDTH'(i), 1'b0);
    @(negedge clk);
    check_eq("fill_full",  32'(full),  1);
    check_eq("fill_count", 32'(count), 32);
    check_eq("fill_head",  32'(dout),  32'h01);

    // Write while full alongside a read: pop happens, write is dropped, OVF sticks.
    step(1'b1, 8'hAA, 1'b1);
    @(negedge clk);
    check_eq("ovf_count", 32'(count), 31);
    check_eq("ovf_flag",  32'(ovf),   1);
    check_eq("ovf_head",  32'(dout),  32'h02);
    while (sb_q.size() != 0) step(1'b0, 8'h00, 1'b1);

    // Steady occupancy of 3 with simultaneous read and write.
    for (int i = 0; i < 3; i++) step(1'b1, WIDTH'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, WIDTH'(8'hD0 + i), 1'b1);
      check_eq("steady_count", 32'(count), 3);
    end
    while (sb_q.size() != 0) step(1'b0, 8'h00, 1'b1);

    // Underflow on empty read, then first-word fall-through.
    step(1'b0, 8'h00, 1'b1);
    check_eq("udf_flag",  32'(udf),   1);
    check_eq("udf_count", 32'(count), 0);
    step(1'b1, 8'h5C, 1'b0);
    check_eq("fwft_valid", 32'(valid), 1);
    check_eq("fwft_dout",  32'(dout),  32'h5C);
    step(1'b0, 8'h00, 1'b1);

    // Random traffic biased to reach both full and empty.
    for (int i = 0; i < 600; i++) begin
      logic wr, rd;
      if ((i / 100) % 2 == 0) begin
        wr = ($urandom_range(0, 9) < 7);
        rd = ($urandom_range(0, 9) < 3);
      end else begin
        wr = ($urandom_range(0, 9) < 3);
        rd = ($urandom_range(0, 9) < 7);
      end
      step(wr, WIDTH'($urandom), rd);
    end
    @(negedge clk);
    check_state();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
